mini_cpu_data_path: RTL and testbench
=====================================

// Module: mini_cpu_data_path
// PURPOSE
//  32-bit single-bus datapath of the mini CPU: 16 GPRs, PC, IR, MAR, MDR, Y, 64-bit Z,
//  HI/LO, in/out ports, 512x32 RAM, select-and-encode logic, ALU and CON branch flag.
//  Driven cycle by cycle by the external control unit, which asserts the *in/*out strobes.
//  All internal bus sources and register decode strobes are exported for debug.
// PARAMETERS
//  MEM_DEPTH  512  RAM words (address = MAR[8:0])
// PORTS
//  Clock  in  1   single clock; all registers load on rising edge when enabled
//  clear  in  1   reset, asynchronous, active-low
//  Read, Write, strobe  in 1 each  RAM read / RAM write / in-port load
//  BAout, Gra, Grb, Grc, Rin, Rout, CONin  in 1 each  select-encode and CON-FF controls
//  input_data  in  32  external in-port data
//  IRin  in 1;  op  in 5  ALU opcode
//  HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Yout, RAMout, Cout  in 1 each  bus drivers
//  HIin, LOin, ZHighin, Zlowin, PCin, MDRin, OutPortin, Yin, MARin, IncPC  in 1 each  loads
//  BusOut, mdrData, ZHighWire, ZLowWire  out 32 each  bus, MDR, Z high/low (ALU result, pre-register)
//  BusMuxInR0..R15, Zhigh, Zlow, PCout, InPortout, Yout, HI, LO, Ramout  out 32 each  bus sources
//  output_data out 32 out-port reg; irOut out 32 IR; branchCompare out 1 CON flag
//  R0out..R15out, R0in..R15in  out 1 each  decoded GPR strobes; to_decode out 4 selected reg field
// BEHAVIOUR
//  Reset (clear=0): all GPRs, PC, IR, MAR, MDR, Y, Z, HI, LO, out-port, in-port, CON -> 0. RAM untouched.
//  IR fields: [31:27] opcode, Ra [26:23], Rb [22:19], Rc [18:15], C2 [20:19], C = sext(IR[18:0]).
//  to_decode = Gra?Ra : Grb?Rb : Grc?Rc : 0; 4->16 decode D.
//   Rxin = D[x]&Rin; Rxout = D[x]&(Rout|BAout). R0 under BAout drives 0 onto bus.
//  Bus mux (combinational, fixed priority): R0..R15, HI, LO, Zhigh, Zlow, PC, MDR, InPort,
//   C (Cout), Y, RAM[MAR] (RAMout); no source -> 0.
//  ALU: A=Y, B=BusOut, 64-bit result {ZHighWire,ZLowWire}; Z loads high/low on ZHighin/Zlowin.
//   IncPC overrides op: Z = BusOut+1. op: 00011 add, 00100 sub, 00101 shr, 00110 shra,
//   00111 shl, 01000 ror, 01001 rol, 01010 and, 01011 or, 01111 mul (signed 64-bit),
//   10000 div (lo=quotient, hi=remainder; div-by-0 -> 0), 10001 neg, 10010 not; others -> 0.
//   Shift/rotate amount = B[4:0]; 32-bit ops zero the high word.
//  MDR: MDRin&Read loads RAM[MAR]; MDRin&~Read loads BusOut. Write=1: RAM[MAR] <= MDR on edge.
//  RAM read is combinational (asynchronous) on MAR; MAR loads BusOut[8:0] on MARin.
//  PC/IR/Y/HI/LO/output_data load BusOut on respective enables; strobe loads input_data.
//  CON FF on CONin: C2 00 bus==0, 01 bus!=0, 10 bus[31]==0 && bus!=0, 11 bus[31]==1.
//  Simultaneous load and reset: reset wins. Several drivers: priority above, no contention.
// TESTING
//  Reset: pulse clear low mid-run -> every register and branchCompare read 0 immediately.
//  Fetch: PC=0, PCout+MARin+IncPC+Z loads -> Zlow=1; Zlowout+PCin -> PC=1; Read+MDRin -> MDR=RAM[0].
//  ldi: IR Ra=2,Rb=0,C=0x5; Grb+BAout+Yin -> Y=0; Cout+op=00011 -> Zlow=5; Gra+Rin+Zlowout -> R2=5.
//  ALU: Y=0xFFFFFFFF, bus=2, mul -> Z=0xFFFFFFFF_FFFFFFFE; div 7/2 -> lo=3, hi=1.
//  Memory: MAR=10, MDR=0x1234, Write -> RAMout puts 0x1234 on bus.
//  Branch: IR C2=10, bus=50, CONin -> branchCompare=1; bus=0 -> 0; C2=11 bus=-1 -> 1.

Source files
------------

// File: rtl/mini_cpu_data_path.sv
// mini_cpu_data_path
// 32-bit single-bus datapath of the mini CPU. The external control unit asserts
// the *out strobes to choose the bus driver and the *in strobes to load registers.
//
// Ports
//   Clock, clear            rising-edge clock; asynchronous active-low reset
//   Read, Write, strobe     RAM read into MDR, RAM write from MDR, in-port load
//   BAout/Gra/Grb/Grc/Rin/Rout/CONin  select-and-encode and CON flag controls
//   input_data              external in-port data
//   IRin, op                IR load, ALU opcode
//   HIout..Cout             bus driver requests (fixed priority, see bus mux)
//   HIin..IncPC             register loads; IncPC makes the ALU compute bus+1
//   BusOut, mdrData         bus value, MDR contents
//   ZHighWire, ZLowWire     ALU result before the Z register
//   BusMuxInR0..R15, Zhigh, Zlow, HI, LO, Ramout  bus sources for debug
//   BusMuxInPC, BusMuxInInPort, BusMuxInY  PC / in-port / Y bus sources (the names
//                           PCout, InPortout and Yout are taken by driver strobes)
//   output_data, irOut, branchCompare      out-port, IR, CON flag
//   R0out..R15out, R0in..R15in, to_decode  decoded GPR strobes and selected field
module mini_cpu_data_path #(
    parameter int MEM_DEPTH = 512
) (
    input  logic        Clock,
    input  logic        clear,
    input  logic        Read,
    input  logic        Write,
    input  logic        strobe,
    input  logic        BAout,
    input  logic        Gra,
    input  logic        Grb,
    input  logic        Grc,
    input  logic        Rin,
    input  logic        Rout,
    input  logic        CONin,
    input  logic [31:0] input_data,
    input  logic        IRin,
    input  logic [4:0]  op,
    input  logic        HIout,
    input  logic        LOout,
    input  logic        Zhighout,
    input  logic        Zlowout,
    input  logic        PCout,
    input  logic        MDRout,
    input  logic        InPortout,
    input  logic        Yout,
    input  logic        RAMout,
    input  logic        Cout,
    input  logic        HIin,
    input  logic        LOin,
    input  logic        ZHighin,
    input  logic        Zlowin,
    input  logic        PCin,
    input  logic        MDRin,
    input  logic        OutPortin,
    input  logic        Yin,
    input  logic        MARin,
    input  logic        IncPC,
    output logic [31:0] BusOut,
    output logic [31:0] mdrData,
    output logic [31:0] ZHighWire,
    output logic [31:0] ZLowWire,
    output logic [31:0] BusMuxInR0,
    output logic [31:0] BusMuxInR1,
    output logic [31:0] BusMuxInR2,
    output logic [31:0] BusMuxInR3,
    output logic [31:0] BusMuxInR4,
    output logic [31:0] BusMuxInR5,
    output logic [31:0] BusMuxInR6,
    output logic [31:0] BusMuxInR7,
    output logic [31:0] BusMuxInR8,
    output logic [31:0] BusMuxInR9,
    output logic [31:0] BusMuxInR10,
    output logic [31:0] BusMuxInR11,
    output logic [31:0] BusMuxInR12,
    output logic [31:0] BusMuxInR13,
    output logic [31:0] BusMuxInR14,
    output logic [31:0] BusMuxInR15,
    output logic [31:0] Zhigh,
    output logic [31:0] Zlow,
    output logic [31:0] BusMuxInPC,
    output logic [31:0] BusMuxInInPort,
    output logic [31:0] BusMuxInY,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] Ramout,
    output logic [31:0] output_data,
    output logic [31:0] irOut,
    output logic        branchCompare,
    output logic        R0out,
    output logic        R1out,
    output logic        R2out,
    output logic        R3out,
    output logic        R4out,
    output logic        R5out,
    output logic        R6out,
    output logic        R7out,
    output logic        R8out,
    output logic        R9out,
    output logic        R10out,
    output logic        R11out,
    output logic        R12out,
    output logic        R13out,
    output logic        R14out,
    output logic        R15out,
    output logic        R0in,
    output logic        R1in,
    output logic        R2in,
    output logic        R3in,
    output logic        R4in,
    output logic        R5in,
    output logic        R6in,
    output logic        R7in,
    output logic        R8in,
    output logic        R9in,
    output logic        R10in,
    output logic        R11in,
    output logic        R12in,
    output logic        R13in,
    output logic        R14in,
    output logic        R15in,
    output logic [3:0]  to_decode
);
    localparam int DATA_W = 32;
    localparam int AW     = $clog2(MEM_DEPTH);

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHRA = 5'b00110;
    localparam logic [4:0] OP_SHL  = 5'b00111;
    localparam logic [4:0] OP_ROR  = 5'b01000;
    localparam logic [4:0] OP_ROL  = 5'b01001;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    logic [DATA_W-1:0] gpr [16];
    logic [DATA_W-1:0] pc_q, ir_q, mdr_q, y_q, zhi_q, zlo_q, hi_q, lo_q;
    logic [DATA_W-1:0] inport_q, outport_q;
    logic [AW-1:0]     mar_q;
    logic              con_q;
    logic [DATA_W-1:0] mem [MEM_DEPTH];

    logic [DATA_W-1:0] bus;
    logic [DATA_W-1:0] ram_rd;
    logic [DATA_W-1:0] c_sext;
    logic [63:0]       alu_res;
    logic [3:0]        sel;
    logic [15:0]       dec;
    logic [15:0]       reg_in;
    logic [15:0]       reg_out;
    logic              con_next;

    // 64-bit ALU result; 32-bit operations leave the high word zero.
    // Shift and rotate amounts come from b[4:0]; mul/div treat operands as signed.
    function automatic logic [63:0] alu_f(input logic [4:0]  f_op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [4:0]         n;
        logic [5:0]         n_inv;
        logic signed [31:0] a_s;
        logic signed [31:0] sra;
        logic signed [63:0] a_w;
        logic signed [63:0] b_w;
        logic signed [63:0] quo;
        logic signed [63:0] rem;
        logic [63:0]        r;
        n     = b[4:0];
        n_inv = 6'd32 - {1'b0, n};
        a_s   = a;
        sra   = a_s >>> n;
        a_w   = {{32{a[31]}}, a};
        b_w   = {{32{b[31]}}, b};
        quo   = '0;
        rem   = '0;
        r     = '0;
        case (f_op)
            OP_ADD:  r = {32'd0, a + b};
            OP_SUB:  r = {32'd0, a - b};
            OP_SHR:  r = {32'd0, a >> n};
            OP_SHRA: r = {32'd0, sra};
            OP_SHL:  r = {32'd0, a << n};
            // A 32-bit shift by 32 yields 0, so n == 0 needs no special case.
            OP_ROR:  r = {32'd0, (a >> n) | (a << n_inv)};
            OP_ROL:  r = {32'd0, (a << n) | (a >> n_inv)};
            OP_AND:  r = {32'd0, a & b};
            OP_OR:   r = {32'd0, a | b};
            OP_MUL:  r = a_w * b_w;
            OP_DIV: begin
                // Dividing in 64 bits keeps -2^31 / -1 well defined.
                if (b != '0) begin
                    quo = a_w / b_w;
                    rem = a_w % b_w;
                    r   = (rem << 32) | (quo & 64'h0000_0000_FFFF_FFFF);
                end
            end
            OP_NEG:  r = {32'd0, 32'd0 - b};
            OP_NOT:  r = {32'd0, ~b};
            default: r = '0;
        endcase
        return r;
    endfunction

    assign c_sext = {{13{ir_q[18]}}, ir_q[18:0]};
    assign ram_rd = mem[mar_q];

    // Select-and-encode: pick the IR register field, then one-hot decode it.
    always_comb begin
        sel = 4'd0;
        if (Gra)      sel = ir_q[26:23];
        else if (Grb) sel = ir_q[22:19];
        else if (Grc) sel = ir_q[18:15];
    end

    assign dec     = 16'd1 << sel;
    assign reg_in  = dec & {16{Rin}};
    assign reg_out = dec & {16{Rout | BAout}};

    // Bus mux with fixed priority; only one GPR strobe can be active at a time,
    // and R0 under BAout reads as zero so it can serve as a base-address of 0.
    always_comb begin
        bus = '0;
        if (|reg_out)       bus = (sel == 4'd0 && BAout) ? '0 : gpr[sel];
        else if (HIout)     bus = hi_q;
        else if (LOout)     bus = lo_q;
        else if (Zhighout)  bus = zhi_q;
        else if (Zlowout)   bus = zlo_q;
        else if (PCout)     bus = pc_q;
        else if (MDRout)    bus = mdr_q;
        else if (InPortout) bus = inport_q;
        else if (Cout)      bus = c_sext;
        else if (Yout)      bus = y_q;
        else if (RAMout)    bus = ram_rd;
    end

    assign alu_res = IncPC ? {32'd0, bus + 32'd1} : alu_f(op, y_q, bus);

    // CON flag condition selected by IR C2 field.
    always_comb begin
        con_next = 1'b0;
        case (ir_q[20:19])
            2'b00: con_next = (bus == '0);
            2'b01: con_next = (bus != '0);
            2'b10: con_next = !bus[31] && (bus != '0);
            2'b11: con_next = bus[31];
            default: con_next = 1'b0;
        endcase
    end

    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < 16; i++) gpr[i] <= '0;
            pc_q      <= '0;
            ir_q      <= '0;
            mar_q     <= '0;
            mdr_q     <= '0;
            y_q       <= '0;
            zhi_q     <= '0;
            zlo_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            inport_q  <= '0;
            outport_q <= '0;
            con_q     <= 1'b0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (reg_in[i]) gpr[i] <= bus;
            end
            if (PCin)      pc_q      <= bus;
            if (IRin)      ir_q      <= bus;
            if (Yin)       y_q       <= bus;
            if (HIin)      hi_q      <= bus;
            if (LOin)      lo_q      <= bus;
            if (OutPortin) outport_q <= bus;
            if (strobe)    inport_q  <= input_data;
            if (MARin)     mar_q     <= bus[AW-1:0];
            if (MDRin)     mdr_q     <= Read ? ram_rd : bus;
            if (ZHighin)   zhi_q     <= alu_res[63:32];
            if (Zlowin)    zlo_q     <= alu_res[31:0];
            if (CONin)     con_q     <= con_next;
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge Clock) begin
        if (Write) mem[mar_q] <= mdr_q;
    end

    assign BusOut         = bus;
    assign mdrData        = mdr_q;
    assign ZHighWire      = alu_res[63:32];
    assign ZLowWire       = alu_res[31:0];
    assign Zhigh          = zhi_q;
    assign Zlow           = zlo_q;
    assign BusMuxInPC     = pc_q;
    assign BusMuxInInPort = inport_q;
    assign BusMuxInY      = y_q;
    assign HI             = hi_q;
    assign LO             = lo_q;
    assign Ramout         = ram_rd;
    assign output_data    = outport_q;
    assign irOut          = ir_q;
    assign branchCompare  = con_q;
    assign to_decode      = sel;

    assign BusMuxInR0  = gpr[0];
    assign BusMuxInR1  = gpr[1];
    assign BusMuxInR2  = gpr[2];
    assign BusMuxInR3  = gpr[3];
    assign BusMuxInR4  = gpr[4];
    assign BusMuxInR5  = gpr[5];
    assign BusMuxInR6  = gpr[6];
    assign BusMuxInR7  = gpr[7];
    assign BusMuxInR8  = gpr[8];
    assign BusMuxInR9  = gpr[9];
    assign BusMuxInR10 = gpr[10];
    assign BusMuxInR11 = gpr[11];
    assign BusMuxInR12 = gpr[12];
    assign BusMuxInR13 = gpr[13];
    assign BusMuxInR14 = gpr[14];
    assign BusMuxInR15 = gpr[15];

    assign {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
            R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out} = reg_out;
    assign {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
            R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in} = reg_in;

endmodule

// File: tb/tb_mini_cpu_data_path.sv
// Bench for mini_cpu_data_path: microstep sequences from the control unit's view,
// with expected values from spec-level arithmetic and a small register model.
module tb_mini_cpu_data_path;
    logic        Clock = 1'b0;
    logic        clear;
    logic        Read, Write, strobe, BAout, Gra, Grb, Grc, Rin, Rout, CONin;
    logic [31:0] input_data;
    logic        IRin;
    logic [4:0]  op;
    logic        HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Yout, RAMout, Cout;
    logic        HIin, LOin, ZHighin, Zlowin, PCin, MDRin, OutPortin, Yin, MARin, IncPC;
    logic [31:0] BusOut, mdrData, ZHighWire, ZLowWire;
    logic [31:0] BusMuxInR0, BusMuxInR1, BusMuxInR2, BusMuxInR3, BusMuxInR4, BusMuxInR5;
    logic [31:0] BusMuxInR6, BusMuxInR7, BusMuxInR8, BusMuxInR9, BusMuxInR10, BusMuxInR11;
    logic [31:0] BusMuxInR12, BusMuxInR13, BusMuxInR14, BusMuxInR15;
    logic [31:0] Zhigh, Zlow, BusMuxInPC, BusMuxInInPort, BusMuxInY, HI, LO, Ramout;
    logic [31:0] output_data, irOut;
    logic        branchCompare;
    logic        R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out;
    logic        R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out;
    logic        R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in;
    logic        R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in;
    logic [3:0]  to_decode;

    logic [15:0] rout_v, rin_v;
    logic [31:0] gpr_v [16];
    logic [31:0] m_gpr [16];
    logic [31:0] m_mem [int];
    int          passed, total;

    localparam logic [4:0] OP_ADD = 5'b00011, OP_SUB = 5'b00100, OP_SHR = 5'b00101;
    localparam logic [4:0] OP_SHRA = 5'b00110, OP_SHL = 5'b00111, OP_ROR = 5'b01000;
    localparam logic [4:0] OP_ROL = 5'b01001, OP_AND = 5'b01010, OP_OR = 5'b01011;
    localparam logic [4:0] OP_MUL = 5'b01111, OP_DIV = 5'b10000, OP_NEG = 5'b10001;
    localparam logic [4:0] OP_NOT = 5'b10010;

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } alu_vec_t;

    assign rout_v = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                     R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
    assign rin_v  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                     R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
    assign gpr_v[0]  = BusMuxInR0;   assign gpr_v[1]  = BusMuxInR1;
    assign gpr_v[2]  = BusMuxInR2;   assign gpr_v[3]  = BusMuxInR3;
    assign gpr_v[4]  = BusMuxInR4;   assign gpr_v[5]  = BusMuxInR5;
    assign gpr_v[6]  = BusMuxInR6;   assign gpr_v[7]  = BusMuxInR7;
    assign gpr_v[8]  = BusMuxInR8;   assign gpr_v[9]  = BusMuxInR9;
    assign gpr_v[10] = BusMuxInR10;  assign gpr_v[11] = BusMuxInR11;
    assign gpr_v[12] = BusMuxInR12;  assign gpr_v[13] = BusMuxInR13;
    assign gpr_v[14] = BusMuxInR14;  assign gpr_v[15] = BusMuxInR15;

    mini_cpu_data_path #(.MEM_DEPTH(512)) dut (
        .Clock(Clock), .clear(clear), .Read(Read), .Write(Write), .strobe(strobe),
        .BAout(BAout), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .CONin(CONin), .input_data(input_data), .IRin(IRin), .op(op),
        .HIout(HIout), .LOout(LOout), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .PCout(PCout), .MDRout(MDRout), .InPortout(InPortout), .Yout(Yout),
        .RAMout(RAMout), .Cout(Cout), .HIin(HIin), .LOin(LOin), .ZHighin(ZHighin),
        .Zlowin(Zlowin), .PCin(PCin), .MDRin(MDRin), .OutPortin(OutPortin), .Yin(Yin),
        .MARin(MARin), .IncPC(IncPC), .BusOut(BusOut), .mdrData(mdrData),
        .ZHighWire(ZHighWire), .ZLowWire(ZLowWire),
        .BusMuxInR0(BusMuxInR0), .BusMuxInR1(BusMuxInR1), .BusMuxInR2(BusMuxInR2),
        .BusMuxInR3(BusMuxInR3), .BusMuxInR4(BusMuxInR4), .BusMuxInR5(BusMuxInR5),
        .BusMuxInR6(BusMuxInR6), .BusMuxInR7(BusMuxInR7), .BusMuxInR8(BusMuxInR8),
        .BusMuxInR9(BusMuxInR9), .BusMuxInR10(BusMuxInR10), .BusMuxInR11(BusMuxInR11),
        .BusMuxInR12(BusMuxInR12), .BusMuxInR13(BusMuxInR13), .BusMuxInR14(BusMuxInR14),
        .BusMuxInR15(BusMuxInR15), .Zhigh(Zhigh), .Zlow(Zlow), .BusMuxInPC(BusMuxInPC),
        .BusMuxInInPort(BusMuxInInPort), .BusMuxInY(BusMuxInY), .HI(HI), .LO(LO),
        .Ramout(Ramout), .output_data(output_data), .irOut(irOut),
        .branchCompare(branchCompare),
        .R0out(R0out), .R1out(R1out), .R2out(R2out), .R3out(R3out), .R4out(R4out),
        .R5out(R5out), .R6out(R6out), .R7out(R7out), .R8out(R8out), .R9out(R9out),
        .R10out(R10out), .R11out(R11out), .R12out(R12out), .R13out(R13out),
        .R14out(R14out), .R15out(R15out),
        .R0in(R0in), .R1in(R1in), .R2in(R2in), .R3in(R3in), .R4in(R4in),
        .R5in(R5in), .R6in(R6in), .R7in(R7in), .R8in(R8in), .R9in(R9in),
        .R10in(R10in), .R11in(R11in), .R12in(R12in), .R13in(R13in),
        .R14in(R14in), .R15in(R15in), .to_decode(to_decode)
    );

    always #5 Clock = ~Clock;

    // Reference ALU from the instruction-set rules: shifts/rotates one bit at a time.
    function automatic logic [63:0] alu_ref(input logic [4:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
        longint      sa, sb, p;
        int          n;
        logic [31:0] t;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        n  = int'(b[4:0]);
        t  = a;
        case (o)
            OP_ADD:  return {32'd0, a + b};
            OP_SUB:  return {32'd0, a - b};
            OP_SHR:  begin repeat (n) t = {1'b0, t[31:1]};  return {32'd0, t}; end
            OP_SHRA: begin repeat (n) t = {t[31], t[31:1]}; return {32'd0, t}; end
            OP_SHL:  begin repeat (n) t = {t[30:0], 1'b0};  return {32'd0, t}; end
            OP_ROR:  begin repeat (n) t = {t[0], t[31:1]};  return {32'd0, t}; end
            OP_ROL:  begin repeat (n) t = {t[30:0], t[31]}; return {32'd0, t}; end
            OP_AND:  return {32'd0, a & b};
            OP_OR:   return {32'd0, a | b};
            OP_MUL:  begin p = sa * sb; return p; end
            OP_DIV:  begin
                if (b == 32'd0) return 64'd0;
                return {32'(sa % sb), 32'(sa / sb)};
            end
            OP_NEG:  return {32'd0, -b};
            OP_NOT:  return {32'd0, ~b};
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic con_ref(input logic [1:0] c2, input logic [31:0] v);
        case (c2)
            2'd0:    return v == 32'd0;
            2'd1:    return v != 32'd0;
            2'd2:    return $signed(v) > 0;
            default: return $signed(v) < 0;
        endcase
    endfunction

    task automatic idle();
        Read = 0; Write = 0; strobe = 0; BAout = 0; Gra = 0; Grb = 0; Grc = 0;
        Rin = 0; Rout = 0; CONin = 0; IRin = 0; op = 5'd0;
        HIout = 0; LOout = 0; Zhighout = 0; Zlowout = 0; PCout = 0; MDRout = 0;
        InPortout = 0; Yout = 0; RAMout = 0; Cout = 0;
        HIin = 0; LOin = 0; ZHighin = 0; Zlowin = 0; PCin = 0; MDRin = 0;
        OutPortin = 0; Yin = 0; MARin = 0; IncPC = 0;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Latch v into the in-port, then leave the in-port driving the bus.
    task automatic drive_bus(input logic [31:0] v);
        idle();
        input_data = v; strobe = 1;
        tick();
        strobe = 0; InPortout = 1;
    endtask

    task automatic load_ir(input logic [31:0] v);
        drive_bus(v); IRin = 1; tick(); idle();
    endtask

    task automatic write_mem(input logic [31:0] addr, input logic [31:0] data);
        drive_bus(addr); MARin = 1; tick();
        drive_bus(data); MDRin = 1; tick(); idle();
        Write = 1; tick(); idle();
        m_mem[int'(addr[8:0])] = data;
    endtask

    task automatic test_reset();
        int nz;
        nz = 0;
        for (int i = 0; i < 16; i++) if (gpr_v[i] !== 32'd0) nz++;
        total++; if (nz != 0) $display("FAIL reset_gprs: nonzero=%0d want 0", nz); else passed++;
        total++; if (BusMuxInPC !== 32'd0) $display("FAIL reset_pc: got %h want 0", BusMuxInPC); else passed++;
        total++; if ({Zhigh, Zlow} !== 64'd0) $display("FAIL reset_z: got %h want 0", {Zhigh, Zlow}); else passed++;
        total++; if ({HI, LO, BusMuxInY, irOut} !== 128'd0) $display("FAIL reset_hilo_y_ir: got %h want 0", {HI, LO, BusMuxInY, irOut}); else passed++;
        total++; if ({mdrData, output_data, BusMuxInInPort} !== 96'd0) $display("FAIL reset_mdr_ports: got %h want 0", {mdrData, output_data, BusMuxInInPort}); else passed++;
        total++; if (branchCompare !== 1'b0) $display("FAIL reset_con: got %b want 0", branchCompare); else passed++;
        total++; if (BusOut !== 32'd0) $display("FAIL reset_bus_idle: got %h want 0", BusOut); else passed++;
    endtask

    task automatic test_memory();
        int addr [6];
        write_mem(32'd10, 32'h0000_1234);
        drive_bus(32'd10); MARin = 1; tick(); idle();
        RAMout = 1; #1;
        total++; if (BusOut !== 32'h1234) $display("FAIL mem_ramout_bus: got %h want 00001234", BusOut); else passed++;
        total++; if (Ramout !== 32'h1234) $display("FAIL mem_ramout_port: got %h want 00001234", Ramout); else passed++;
        idle();
        for (int i = 0; i < 6; i++) begin
            addr[i] = 20 + i * 37 + int'($urandom_range(0, 30));
            write_mem(32'(addr[i]), $urandom);
        end
        for (int i = 5; i >= 0; i--) begin
            drive_bus(32'(addr[i])); MARin = 1; tick(); idle();
            Read = 1; MDRin = 1; tick(); idle();
            total++; if (mdrData !== m_mem[addr[i]]) $display("FAIL mem_read_mdr[%0d]: got %h want %h", addr[i], mdrData, m_mem[addr[i]]); else passed++;
        end
        write_mem(32'd0, 32'hA5A5_0F0F);
    endtask

    task automatic test_fetch();
        #2 clear = 0; #1 clear = 1; #1;
        idle(); PCout = 1; MARin = 1; IncPC = 1; ZHighin = 1; Zlowin = 1; #1;
        total++; if (ZLowWire !== 32'd1) $display("FAIL fetch_incpc_wire: got %h want 1", ZLowWire); else passed++;
        tick(); idle();
        total++; if ({Zhigh, Zlow} !== 64'd1) $display("FAIL fetch_z: got %h want 1", {Zhigh, Zlow}); else passed++;
        Zlowout = 1; PCin = 1; tick(); idle();
        total++; if (BusMuxInPC !== 32'd1) $display("FAIL fetch_pc: got %h want 1", BusMuxInPC); else passed++;
        Read = 1; MDRin = 1; tick(); idle();
        total++; if (mdrData !== 32'hA5A5_0F0F) $display("FAIL fetch_mdr: got %h want a5a50f0f", mdrData); else passed++;
        MDRout = 1; IRin = 1; tick(); idle();
        total++; if (irOut !== 32'hA5A5_0F0F) $display("FAIL fetch_ir: got %h want a5a50f0f", irOut); else passed++;
    endtask

    task automatic test_ldi();
        load_ir((32'd2 << 23) | 32'd5);
        drive_bus(32'hDEAD_BEEF); Grb = 1; Rin = 1; tick(); idle();
        total++; if (BusMuxInR0 !== 32'hDEAD_BEEF) $display("FAIL ldi_r0_preload: got %h want deadbeef", BusMuxInR0); else passed++;
        Grb = 1; Rout = 1; #1;
        total++; if (BusOut !== 32'hDEAD_BEEF) $display("FAIL ldi_r0_rout: got %h want deadbeef", BusOut); else passed++;
        idle(); Grb = 1; BAout = 1; Yin = 1; #1;
        total++; if (BusOut !== 32'd0 || R0out !== 1'b1) $display("FAIL ldi_baout_r0: bus %h r0out %b want 0/1", BusOut, R0out); else passed++;
        tick(); idle();
        total++; if (BusMuxInY !== 32'd0) $display("FAIL ldi_y: got %h want 0", BusMuxInY); else passed++;
        Cout = 1; op = OP_ADD; Zlowin = 1; #1;
        total++; if (BusOut !== 32'd5) $display("FAIL ldi_cout: got %h want 5", BusOut); else passed++;
        tick(); idle();
        total++; if (Zlow !== 32'd5) $display("FAIL ldi_zlow: got %h want 5", Zlow); else passed++;
        Gra = 1; Rin = 1; Zlowout = 1; #1;
        total++; if (rin_v !== 16'h0004) $display("FAIL ldi_r2in: got %h want 0004", rin_v); else passed++;
        tick(); idle();
        total++; if (BusMuxInR2 !== 32'd5) $display("FAIL ldi_r2: got %h want 5", BusMuxInR2); else passed++;
        load_ir(32'h0004_0000);
        Cout = 1; #1;
        total++; if (BusOut !== 32'hFFFC_0000) $display("FAIL cout_sext: got %h want fffc0000", BusOut); else passed++;
        idle();
    endtask

    task automatic test_regfile();
        int j;
        for (int i = 0; i < 16; i++) begin
            m_gpr[i] = $urandom;
            load_ir(32'(i) << 23);
            drive_bus(m_gpr[i]); Gra = 1; Rin = 1; tick(); idle();
        end
        for (int k = 0; k < 16; k++) begin
            j = int'($urandom_range(0, 15));
            load_ir(32'(j) << 19);
            Grb = 1; Rout = 1; #1;
            total++; if (BusOut !== m_gpr[j]) $display("FAIL regfile_read[R%0d]: got %h want %h", j, BusOut, m_gpr[j]); else passed++;
            total++; if (gpr_v[j] !== m_gpr[j]) $display("FAIL regfile_port[R%0d]: got %h want %h", j, gpr_v[j], m_gpr[j]); else passed++;
            idle();
        end
    endtask

    task automatic test_decode();
        logic [31:0] ir;
        logic [5:0]  c;
        logic [3:0]  f;
        for (int k = 0; k < 20; k++) begin
            ir = $urandom;
            load_ir(ir);
            c = 6'($urandom);
            {Gra, Grb, Grc, Rin, Rout, BAout} = c;
            #1;
            f = c[5] ? ir[26:23] : c[4] ? ir[22:19] : c[3] ? ir[18:15] : 4'd0;
            total++; if (to_decode !== f) $display("FAIL decode_field: got %h want %h", to_decode, f); else passed++;
            total++; if (rin_v !== (c[2] ? (16'd1 << f) : 16'd0)) $display("FAIL decode_rin: got %h sel %h", rin_v, f); else passed++;
            total++; if (rout_v !== ((c[1] | c[0]) ? (16'd1 << f) : 16'd0)) $display("FAIL decode_rout: got %h sel %h", rout_v, f); else passed++;
            idle();
        end
    endtask

    task automatic test_bus_priority();
        drive_bus(32'h1111_0001); HIin = 1; tick();
        drive_bus(32'h2222_0002); LOin = 1; tick();
        drive_bus(32'h3333_0003); Yin = 1; tick();
        drive_bus(32'h4444_0004); MDRin = 1; tick();
        drive_bus(32'h5555_0005); idle();
        HIout = 1; LOout = 1; #1;
        total++; if (BusOut !== 32'h1111_0001) $display("FAIL prio_hi_lo: got %h want 11110001", BusOut); else passed++;
        idle(); LOout = 1; PCout = 1; Yout = 1; #1;
        total++; if (BusOut !== 32'h2222_0002) $display("FAIL prio_lo_pc_y: got %h want 22220002", BusOut); else passed++;
        idle(); Yout = 1; RAMout = 1; #1;
        total++; if (BusOut !== 32'h3333_0003) $display("FAIL prio_y_ram: got %h want 33330003", BusOut); else passed++;
        idle(); MDRout = 1; InPortout = 1; #1;
        total++; if (BusOut !== 32'h4444_0004) $display("FAIL prio_mdr_inport: got %h want 44440004", BusOut); else passed++;
        idle(); #1;
        total++; if (BusOut !== 32'd0) $display("FAIL prio_none: got %h want 0", BusOut); else passed++;
        load_ir(32'd3 << 19);
        Grb = 1; Rout = 1; HIout = 1; #1;
        total++; if (BusOut !== m_gpr[3]) $display("FAIL prio_gpr_hi: got %h want %h", BusOut, m_gpr[3]); else passed++;
        drive_bus(32'h6666_0006); OutPortin = 1; tick(); idle();
        total++; if (output_data !== 32'h6666_0006) $display("FAIL outport: got %h want 66660006", output_data); else passed++;
    endtask

    task automatic test_alu();
        alu_vec_t    vq[$];
        alu_vec_t    v;
        logic [4:0]  ops [17];
        ops = '{OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR,
                OP_MUL, OP_DIV, OP_NEG, OP_NOT, 5'd0, 5'd1, 5'd12, 5'd31};
        vq.push_back({OP_MUL,  32'hFFFF_FFFF, 32'd2,        64'hFFFF_FFFF_FFFF_FFFE});
        vq.push_back({OP_DIV,  32'd7,         32'd2,        64'h0000_0001_0000_0003});
        vq.push_back({OP_DIV,  32'hFFFF_FFF9, 32'd2,        64'hFFFF_FFFF_FFFF_FFFD});
        vq.push_back({OP_DIV,  32'd5,         32'd0,        64'd0});
        vq.push_back({OP_SHRA, 32'h8000_0000, 32'd4,        64'h0000_0000_F800_0000});
        vq.push_back({OP_SHR,  32'h8000_0000, 32'd31,       64'd1});
        vq.push_back({OP_ROR,  32'd1,         32'd1,        64'h0000_0000_8000_0000});
        vq.push_back({OP_ROL,  32'h8000_0000, 32'd1,        64'd1});
        vq.push_back({OP_SHL,  32'd3,         32'h0000_0020, 64'd3});
        vq.push_back({OP_ADD,  32'hFFFF_FFFF, 32'd1,        64'd0});
        vq.push_back({OP_SUB,  32'd0,         32'd1,        64'h0000_0000_FFFF_FFFF});
        vq.push_back({OP_NEG,  32'd9,         32'd5,        64'h0000_0000_FFFF_FFFB});
        vq.push_back({OP_NOT,  32'd9,         32'd0,        64'h0000_0000_FFFF_FFFF});
        vq.push_back({5'd31,   32'd9,         32'd5,        64'd0});
        for (int k = 0; k < 30; k++) begin
            v.op = ops[$urandom_range(0, 16)];
            v.a  = $urandom;
            v.b  = (v.op == OP_DIV && $urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 20)) : $urandom;
            v.exp = alu_ref(v.op, v.a, v.b);
            vq.push_back(v);
        end
        foreach (vq[k]) begin
            v = vq[k];
            drive_bus(v.a); Yin = 1; tick();
            drive_bus(v.b); op = v.op; ZHighin = 1; Zlowin = 1; #1;
            total++; if ({ZHighWire, ZLowWire} !== v.exp) $display("FAIL alu_wire op=%b a=%h b=%h: got %h want %h", v.op, v.a, v.b, {ZHighWire, ZLowWire}, v.exp); else passed++;
            tick(); idle();
            total++; if ({Zhigh, Zlow} !== v.exp) $display("FAIL alu_zreg op=%b a=%h b=%h: got %h want %h", v.op, v.a, v.b, {Zhigh, Zlow}, v.exp); else passed++;
        end
    endtask

    task automatic test_incpc();
        logic [31:0] b [3];
        b = '{32'hFFFF_FFFF, 32'd41, $urandom};
        for (int k = 0; k < 3; k++) begin
            drive_bus(b[k]); IncPC = 1; op = OP_SUB; ZHighin = 1; Zlowin = 1; #1;
            total++; if ({ZHighWire, ZLowWire} !== {32'd0, b[k] + 32'd1}) $display("FAIL incpc_wire b=%h: got %h", b[k], {ZHighWire, ZLowWire}); else passed++;
            tick(); idle();
            total++; if (Zlow !== b[k] + 32'd1) $display("FAIL incpc_zlow b=%h: got %h want %h", b[k], Zlow, b[k] + 32'd1); else passed++;
        end
    endtask

    task automatic test_branch();
        logic [1:0]  c2 [7];
        logic [31:0] bv [7];
        logic        ex [7];
        logic [1:0]  rc;
        logic [31:0] rv;
        logic        re;
        c2 = '{2'd2, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        bv = '{32'd50, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'h8000_0000, 32'd5};
        ex = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 23; k++) begin
            if (k < 7) begin
                rc = c2[k]; rv = bv[k]; re = ex[k];
            end else begin
                rc = 2'($urandom);
                rv = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
                re = con_ref(rc, rv);
            end
            load_ir(($urandom & 32'hFFE7_FFFF) | (32'(rc) << 19));
            drive_bus(rv); CONin = 1; tick(); idle();
            total++; if (branchCompare !== re) $display("FAIL branch c2=%0d bus=%h: got %b want %b", rc, rv, branchCompare, re); else passed++;
        end
    endtask

    task automatic test_reset_mid();
        int nz;
        load_ir(32'h0008_0000);
        drive_bus(32'hCAFE_F00D);
        PCin = 1; Yin = 1; HIin = 1; LOin = 1; OutPortin = 1; MDRin = 1;
        op = OP_NOT; ZHighin = 1; Zlowin = 1; CONin = 1; Gra = 1; Rin = 1;
        tick(); idle();
        total++; if (branchCompare !== 1'b1 || BusMuxInPC !== 32'hCAFE_F00D) $display("FAIL pre_reset_state: con %b pc %h", branchCompare, BusMuxInPC); else passed++;
        #2 clear = 0; #1;
        nz = 0;
        for (int i = 0; i < 16; i++) if (gpr_v[i] !== 32'd0) nz++;
        total++; if (nz != 0) $display("FAIL midreset_gprs: nonzero=%0d want 0", nz); else passed++;
        total++; if ({BusMuxInPC, irOut, BusMuxInY, HI, LO} !== 160'd0) $display("FAIL midreset_regs: got %h want 0", {BusMuxInPC, irOut, BusMuxInY, HI, LO}); else passed++;
        total++; if ({Zhigh, Zlow, mdrData, output_data, BusMuxInInPort} !== 160'd0) $display("FAIL midreset_z_mdr_ports: got %h want 0", {Zhigh, Zlow, mdrData, output_data, BusMuxInInPort}); else passed++;
        total++; if (branchCompare !== 1'b0) $display("FAIL midreset_con: got %b want 0", branchCompare); else passed++;
        clear = 1; #1;
        drive_bus(32'd10); MARin = 1; tick(); idle();
        RAMout = 1; #1;
        total++; if (BusOut !== 32'h1234) $display("FAIL ram_survives_reset: got %h want 00001234", BusOut); else passed++;
        idle();
    endtask

    initial begin
        passed = 0;
        total  = 0;
        idle();
        input_data = 32'd0;
        clear = 1'b0;
        #2;
        test_reset();
        clear = 1'b1;
        tick();
        test_memory();
        test_fetch();
        test_ldi();
        test_regfile();
        test_decode();
        test_bus_priority();
        test_alu();
        test_incpc();
        test_branch();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
